// File: rtl/weighted_split.sv
// Splits one total across N_INPUT shares in proportion to N_INPUT weights:
// share[i] = floor(total*w[i]/sum(w)), one multiply and serial restoring divide per share.
module weighted_split #(
  parameter int N_INPUT = 4,
  parameter int SIZE    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SIZE-1:0]           total,
  input  logic [N_INPUT*SIZE-1:0]   weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_INPUT*SIZE-1:0]   share,
  output logic [SIZE-1:0]           residue,
  output logic                      zero_weight
);

  localparam int LG    = $clog2(N_INPUT);
  localparam int WS_W  = SIZE + LG;
  localparam int REM_W = WS_W + 1;
  localparam int DIV_W = 2 * SIZE;
  localparam int CNT_W = $clog2(DIV_W + 1);
  localparam logic [LG-1:0] IDX_LAST = LG'(N_INPUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOAD,
    DIV,
    STORE,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LG-1:0]     idx_q, idx_d;
  logic [SIZE-1:0]   total_q, total_d;
  logic [SIZE-1:0]   w_q [N_INPUT];
  logic [SIZE-1:0]   w_d [N_INPUT];
  logic [WS_W-1:0]   wsum_q, wsum_d;
  logic [DIV_W-1:0]  dividend_q, dividend_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [DIV_W-1:0]  quot_q, quot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   share_q [N_INPUT];
  logic [SIZE-1:0]   share_d [N_INPUT];
  logic [SIZE-1:0]   residue_q, residue_d;
  logic              zero_weight_q, zero_weight_d;
  logic              out_valid_q, out_valid_d;

  logic [SIZE-1:0]   w_in [N_INPUT];
  logic [WS_W-1:0]   wsum_in;
  logic [SIZE-1:0]   w_sel;
  logic [DIV_W-1:0]  product;
  logic [REM_W-1:0]  rem_shift;
  logic [REM_W-1:0]  rem_sub;
  logic              rem_ge;

  generate
    for (genvar gi = 0; gi < N_INPUT; gi++) begin : g_lane
      assign w_in[gi]                 = weight[gi*SIZE +: SIZE];
      assign share[gi*SIZE +: SIZE]   = share_q[gi];
    end
  endgenerate

  // Sum is carried LG bits wider than a weight so it can never overflow.
  always_comb begin
    wsum_in = '0;
    for (int i = 0; i < N_INPUT; i++) begin
      wsum_in = wsum_in + WS_W'(w_in[i]);
    end
  end

  assign w_sel     = w_q[idx_q];
  assign product   = DIV_W'(total_q) * DIV_W'(w_sel);
  assign rem_shift = {rem_q[REM_W-2:0], dividend_q[DIV_W-1]};
  assign rem_ge    = (rem_shift >= {1'b0, wsum_q});
  assign rem_sub   = rem_shift - {1'b0, wsum_q};

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    total_d       = total_q;
    w_d           = w_q;
    wsum_d        = wsum_q;
    dividend_d    = dividend_q;
    rem_d         = rem_q;
    quot_d        = quot_q;
    cnt_d         = cnt_q;
    share_d       = share_q;
    residue_d     = residue_q;
    zero_weight_d = zero_weight_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          total_d       = total;
          w_d           = w_in;
          wsum_d        = wsum_in;
          for (int i = 0; i < N_INPUT; i++) begin
            share_d[i] = '0;
          end
          residue_d     = '0;
          zero_weight_d = 1'b0;
          idx_d         = '0;
          state_d       = CHECK;
        end
      end
      CHECK: begin
        // Residue starts as the whole total; each share is then taken out of it.
        residue_d = total_q;
        if (wsum_q == '0) begin
          zero_weight_d = 1'b1;
          state_d       = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        dividend_d = product;
        rem_d      = '0;
        quot_d     = '0;
        cnt_d      = CNT_W'(DIV_W);
        state_d    = DIV;
      end
      DIV: begin
        dividend_d = dividend_q << 1;
        rem_d      = rem_ge ? rem_sub : rem_shift;
        quot_d     = {quot_q[DIV_W-2:0], rem_ge};
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = STORE;
        end
      end
      STORE: begin
        // w[idx] <= wsum, so the quotient always fits in SIZE bits.
        share_d[idx_q] = quot_q[SIZE-1:0];
        residue_d      = residue_q - quot_q[SIZE-1:0];
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + LG'(1);
          state_d = LOAD;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid_d = (state_d == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      total_q       <= '0;
      wsum_q        <= '0;
      dividend_q    <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      cnt_q         <= '0;
      residue_q     <= '0;
      zero_weight_q <= 1'b0;
      out_valid_q   <= 1'b0;
      for (int i = 0; i < N_INPUT; i++) begin
        w_q[i]     <= '0;
        share_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      total_q       <= total_d;
      wsum_q        <= wsum_d;
      dividend_q    <= dividend_d;
      rem_q         <= rem_d;
      quot_q        <= quot_d;
      cnt_q         <= cnt_d;
      residue_q     <= residue_d;
      zero_weight_q <= zero_weight_d;
      out_valid_q   <= out_valid_d;
      for (int i = 0; i < N_INPUT; i++) begin
        w_q[i]     <= w_d[i];
        share_q[i] <= share_d[i];
      end
    end
  end

  // Gated by reset so the block never advertises ready while being reset.
  assign in_ready    = (state_q == IDLE) && !reset;
  assign out_valid   = out_valid_q;
  assign residue     = residue_q;
  assign zero_weight = zero_weight_q;

endmodule

// File: tb/tb_weighted_split.sv
// Directed bench for weighted_split with N_INPUT=4, SIZE=8; each task checks one scenario
// against hand-computed shares, residue and latency.
module tb_weighted_split;
  localparam int N = 4;
  localparam int S = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [S-1:0]     total;
  logic [N*S-1:0]   weight;
  logic             out_valid;
  logic             out_ready;
  logic [N*S-1:0]   share;
  logic [S-1:0]     residue;
  logic             zero_weight;

  int vectors     = 0;
  int miscompares = 0;

  weighted_split #(.N_INPUT(N), .SIZE(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .total       (total),
    .weight      (weight),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .share       (share),
    .residue     (residue),
    .zero_weight (zero_weight)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [S-1:0] t, input logic [N*S-1:0] w);
    total    = t;
    weight   = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 400) begin
      step();
      cycles++;
    end
    if (!out_valid) cycles = -1;
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; total = '0; weight = '0;
    step();
    step();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    vectors++;
    if (out_valid !== 1'b0 || share !== 32'h0 || residue !== 8'h0 || zero_weight !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ov=%0b share=%h res=%0d zw=%0b expected all 0", out_valid, share, residue, zero_weight);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %0b expected 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_even();
    int c;
    start_req(8'd100, {8'd1, 8'd1, 8'd1, 8'd1});
    wait_out(c);
    vectors++;
    if (c !== 73) begin miscompares++; $display("FAIL even_latency: got %0d expected 73", c); end
    vectors++;
    if (share !== {8'd25, 8'd25, 8'd25, 8'd25}) begin miscompares++; $display("FAIL even_share: got %h expected 19191919", share); end
    vectors++;
    if (residue !== 8'd0 || zero_weight !== 1'b0) begin miscompares++; $display("FAIL even_residue: got %0d zw=%0b expected 0 zw=0", residue, zero_weight); end
    take();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL even_return: got rdy=%0b ov=%0b expected 1 0", in_ready, out_valid); end
    $display("test_even: total=100 share=%h residue=%0d cycles=%0d", share, residue, c);
  endtask

  task automatic test_uneven();
    int c;
    start_req(8'd10, {8'd0, 8'd1, 8'd1, 8'd1});
    wait_out(c);
    vectors++;
    if (c !== 73) begin miscompares++; $display("FAIL uneven_latency: got %0d expected 73", c); end
    vectors++;
    if (share !== {8'd0, 8'd3, 8'd3, 8'd3}) begin miscompares++; $display("FAIL uneven_share: got %h expected 00030303", share); end
    vectors++;
    if (residue !== 8'd1) begin miscompares++; $display("FAIL uneven_residue: got %0d expected 1", residue); end
    take();
    $display("test_uneven: total=10 share=%h residue=%0d", share, residue);
  endtask

  task automatic test_max();
    int c;
    start_req(8'd255, {8'd255, 8'd255, 8'd255, 8'd255});
    wait_out(c);
    vectors++;
    if (c !== 73) begin miscompares++; $display("FAIL max_latency: got %0d expected 73", c); end
    vectors++;
    if (share !== {8'd63, 8'd63, 8'd63, 8'd63}) begin miscompares++; $display("FAIL max_share: got %h expected 3f3f3f3f", share); end
    vectors++;
    if (residue !== 8'd3) begin miscompares++; $display("FAIL max_residue: got %0d expected 3", residue); end
    take();
    $display("test_max: total=255 share=%h residue=%0d", share, residue);
  endtask

  task automatic test_zero_weight();
    int c;
    start_req(8'd77, 32'h0);
    wait_out(c);
    vectors++;
    if (c !== 1) begin miscompares++; $display("FAIL zero_latency: got %0d expected 1", c); end
    vectors++;
    if (zero_weight !== 1'b1 || share !== 32'h0) begin miscompares++; $display("FAIL zero_flag: got zw=%0b share=%h expected 1 0", zero_weight, share); end
    vectors++;
    if (residue !== 8'd77) begin miscompares++; $display("FAIL zero_residue: got %0d expected 77", residue); end
    take();
    $display("test_zero_weight: total=77 zw=%0b residue=%0d", zero_weight, residue);
  endtask

  task automatic test_backpressure();
    int c;
    start_req(8'd100, {8'd1, 8'd1, 8'd1, 8'd1});
    wait_out(c);
    vectors++;
    if (c !== 73) begin miscompares++; $display("FAIL bp_latency_a: got %0d expected 73", c); end
    total    = 8'd10;
    weight   = {8'd0, 8'd1, 8'd1, 8'd1};
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || share !== {8'd25, 8'd25, 8'd25, 8'd25} || residue !== 8'd0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got ov=%0b share=%h res=%0d rdy=%0b expected 1 19191919 0 0", i, out_valid, share, residue, in_ready);
      end
    end
    take();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got ov=%0b rdy=%0b expected 0 1", out_valid, in_ready); end
    step();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_accept_b: got rdy=%0b expected 0", in_ready); end
    wait_out(c);
    vectors++;
    if (c !== 73) begin miscompares++; $display("FAIL bp_latency_b: got %0d expected 73", c); end
    vectors++;
    if (share !== {8'd0, 8'd3, 8'd3, 8'd3} || residue !== 8'd1) begin
      miscompares++;
      $display("FAIL bp_result_b: got share=%h res=%0d expected 00030303 1", share, residue);
    end
    take();
    $display("test_backpressure: second share=%h residue=%0d", share, residue);
  endtask

  task automatic test_reset_midrun();
    int c;
    start_req(8'd200, {8'd9, 8'd0, 8'd5, 8'd3});
    repeat (30) step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got ov=%0b expected 0", out_valid); end
    reset = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || share !== 32'h0 || residue !== 8'h0 || zero_weight !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got ov=%0b share=%h res=%0d zw=%0b rdy=%0b expected all 0", out_valid, share, residue, zero_weight, in_ready);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_release: got rdy=%0b expected 1", in_ready); end
    step();
    start_req(8'd200, {8'd9, 8'd0, 8'd5, 8'd3});
    wait_out(c);
    vectors++;
    if (c !== 73) begin miscompares++; $display("FAIL mid_latency: got %0d expected 73", c); end
    vectors++;
    if (share !== {8'd105, 8'd0, 8'd58, 8'd35}) begin miscompares++; $display("FAIL mid_share: got %h expected 69003a23", share); end
    vectors++;
    if (residue !== 8'd2) begin miscompares++; $display("FAIL mid_residue: got %0d expected 2", residue); end
    take();
    $display("test_reset_midrun: total=200 share=%h residue=%0d", share, residue);
  endtask

  initial begin
    test_reset();
    test_even();
    test_uneven();
    test_max();
    test_zero_weight();
    test_backpressure();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
